// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: opcode/funct constants, ALU operation codes
// and the control bundle carried from ID through EX and MEM.
package pipe_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4
    } alu_op_e;

    typedef struct packed {
        logic    alusrc;
        logic    memread;
        logic    memwrite;
        logic    regwrite;
        logic    branch;
        alu_op_e aluop;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '{alusrc: 1'b0, memread: 1'b0, memwrite: 1'b0,
                                   regwrite: 1'b0, branch: 1'b0, aluop: ALU_ADD};

endpackage

// File: rtl/id_decode.sv
// Combinational instruction decoder: opcode/funct -> control bundle,
// destination register and whether the rt field is a real source.
module id_decode
    import pipe_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic [4:0] rt,
    input  logic [4:0] rd,
    output ctrl_t      ctrl,
    output logic [4:0] dest,
    output logic       uses_rt
);

    // Unknown opcodes and unknown R-type functs decode to an all-zero control word.
    always_comb begin
        ctrl    = CTRL_NOP;
        dest    = '0;
        uses_rt = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                uses_rt       = 1'b1;
                dest          = rd;
                ctrl.regwrite = 1'b1;
                case (funct)
                    FN_ADD:  ctrl.aluop = ALU_ADD;
                    FN_SUB:  ctrl.aluop = ALU_SUB;
                    FN_AND:  ctrl.aluop = ALU_AND;
                    FN_OR:   ctrl.aluop = ALU_OR;
                    FN_SLT:  ctrl.aluop = ALU_SLT;
                    default: begin
                        ctrl = CTRL_NOP;
                        dest = '0;
                    end
                endcase
            end
            OP_LW: begin
                ctrl.alusrc   = 1'b1;
                ctrl.memread  = 1'b1;
                ctrl.regwrite = 1'b1;
                dest          = rt;
            end
            OP_SW: begin
                ctrl.alusrc   = 1'b1;
                ctrl.memwrite = 1'b1;
                uses_rt       = 1'b1;
            end
            OP_BEQ: begin
                ctrl.aluop  = ALU_SUB;
                ctrl.branch = 1'b1;
                uses_rt     = 1'b1;
            end
            OP_ADDI: begin
                ctrl.alusrc   = 1'b1;
                ctrl.regwrite = 1'b1;
                dest          = rt;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/id_stage.sv
// Instruction-decode stage: register read addressing, write-back bypass,
// load-use hazard detection and the ID/EX pipeline register.
module id_stage
    import pipe_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             if_valid,
    input  logic [31:0]      if_instr,
    input  logic [XLEN-1:0]  if_pc,
    input  logic             flush,
    output logic             id_stall,
    output logic [4:0]       rf_read1,
    output logic [4:0]       rf_read2,
    input  logic [XLEN-1:0]  rf_data1,
    input  logic [XLEN-1:0]  rf_data2,
    input  logic             wb_we,
    input  logic [4:0]       wb_addr,
    input  logic [XLEN-1:0]  wb_data,
    output logic             ex_valid,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_rs_val,
    output logic [XLEN-1:0]  ex_rt_val,
    output logic [XLEN-1:0]  ex_imm,
    output logic [4:0]       ex_rs,
    output logic [4:0]       ex_rt,
    output logic [4:0]       ex_dest,
    output logic [2:0]       ex_aluop,
    output logic             ex_alusrc,
    output logic             ex_memread,
    output logic             ex_memwrite,
    output logic             ex_regwrite,
    output logic             ex_branch,
    output logic [CNT_W-1:0] stall_cnt
);

    logic [5:0]      opcode;
    logic [5:0]      funct;
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm_ext;
    ctrl_t           dec_ctrl;
    logic [4:0]      dec_dest;
    logic            dec_uses_rt;
    logic [XLEN-1:0] rs_val;
    logic [XLEN-1:0] rt_val;
    logic            hazard;
    ctrl_t           ex_ctrl;

    assign opcode  = if_instr[31:26];
    assign rs      = if_instr[25:21];
    assign rt      = if_instr[20:16];
    assign rd      = if_instr[15:11];
    assign funct   = if_instr[5:0];
    assign imm_ext = {{(XLEN-16){if_instr[15]}}, if_instr[15:0]};

    assign rf_read1 = rs;
    assign rf_read2 = rt;

    id_decode u_decode (
        .opcode  (opcode),
        .funct   (funct),
        .rt      (rt),
        .rd      (rd),
        .ctrl    (dec_ctrl),
        .dest    (dec_dest),
        .uses_rt (dec_uses_rt)
    );

    // Operand select: $0 is hard zero; a same-edge write-back wins over the stale RF read.
    always_comb begin
        rs_val = rf_data1;
        rt_val = rf_data2;
        if (rs == 5'd0)
            rs_val = '0;
        else if (wb_we && wb_addr == rs)
            rs_val = wb_data;
        if (rt == 5'd0)
            rt_val = '0;
        else if (wb_we && wb_addr == rt)
            rt_val = wb_data;
    end

    assign hazard = if_valid && ex_valid && ex_ctrl.memread && (ex_dest != 5'd0) &&
                    ((ex_dest == rs) || (dec_uses_rt && ex_dest == rt));
    assign id_stall = hazard && !flush;

    // ID/EX register: flush or hazard inserts an all-zero bubble, else capture the decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid  <= 1'b0;
            ex_pc     <= '0;
            ex_rs_val <= '0;
            ex_rt_val <= '0;
            ex_imm    <= '0;
            ex_rs     <= '0;
            ex_rt     <= '0;
            ex_dest   <= '0;
            ex_ctrl   <= CTRL_NOP;
        end else if (flush || hazard) begin
            ex_valid  <= 1'b0;
            ex_pc     <= '0;
            ex_rs_val <= '0;
            ex_rt_val <= '0;
            ex_imm    <= '0;
            ex_rs     <= '0;
            ex_rt     <= '0;
            ex_dest   <= '0;
            ex_ctrl   <= CTRL_NOP;
        end else begin
            ex_valid  <= if_valid;
            ex_pc     <= if_pc;
            ex_rs_val <= rs_val;
            ex_rt_val <= rt_val;
            ex_imm    <= imm_ext;
            ex_rs     <= rs;
            ex_rt     <= rt;
            ex_dest   <= dec_dest;
            ex_ctrl   <= dec_ctrl;
        end
    end

    assign ex_aluop    = ex_ctrl.aluop;
    assign ex_alusrc   = ex_ctrl.alusrc;
    assign ex_memread  = ex_ctrl.memread;
    assign ex_memwrite = ex_ctrl.memwrite;
    assign ex_regwrite = ex_ctrl.regwrite;
    assign ex_branch   = ex_ctrl.branch;

    // Saturating count of cycles in which the front end was held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (id_stall && stall_cnt != {CNT_W{1'b1}})
            stall_cnt <= stall_cnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed decode table, hand-written
// load-use / flush / reset sequences, and a randomized run against a
// behavioural model. A narrow stall counter is used so saturation is reached.
module tb_id_stage;

    localparam int XLEN  = 32;
    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             clk;
    logic             rst_n;
    logic             if_valid;
    logic [31:0]      if_instr;
    logic [31:0]      if_pc;
    logic             flush;
    logic             id_stall;
    logic [4:0]       rf_read1, rf_read2;
    logic [31:0]      rf_data1, rf_data2;
    logic             wb_we;
    logic [4:0]       wb_addr;
    logic [31:0]      wb_data;
    logic             ex_valid;
    logic [31:0]      ex_pc, ex_rs_val, ex_rt_val, ex_imm;
    logic [4:0]       ex_rs, ex_rt, ex_dest;
    logic [2:0]       ex_aluop;
    logic             ex_alusrc, ex_memread, ex_memwrite, ex_regwrite, ex_branch;
    logic [CNT_W-1:0] stall_cnt;

    id_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_instr(if_instr),
        .if_pc(if_pc), .flush(flush), .id_stall(id_stall),
        .rf_read1(rf_read1), .rf_read2(rf_read2),
        .rf_data1(rf_data1), .rf_data2(rf_data2),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs_val(ex_rs_val),
        .ex_rt_val(ex_rt_val), .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .ex_dest(ex_dest), .ex_aluop(ex_aluop), .ex_alusrc(ex_alusrc),
        .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
        .ex_regwrite(ex_regwrite), .ex_branch(ex_branch), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc, rs_val, rt_val, imm;
        logic [4:0]  rs, rt, dest;
        logic [2:0]  aluop;
        logic        alusrc, memread, memwrite, regwrite, branch;
    } exm_t;

    typedef struct packed {
        logic       alusrc, memread, memwrite, regwrite, branch;
        logic [2:0] aluop;
        logic [4:0] dest;
        logic       uses_rt;
    } dec_t;

    typedef struct {
        logic [31:0] instr, rf1, rf2;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [31:0] e_rs_val, e_rt_val, e_imm;
        logic [4:0]  e_dest;
        logic [2:0]  e_aluop;
        logic [4:0]  e_ctl;   // {alusrc, memread, memwrite, regwrite, branch}
    } vec_t;

    vec_t tbl [14];

    task automatic check(input string nm, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    function automatic exm_t get_ex();
        return {ex_valid, ex_pc, ex_rs_val, ex_rt_val, ex_imm, ex_rs, ex_rt, ex_dest,
                ex_aluop, ex_alusrc, ex_memread, ex_memwrite, ex_regwrite, ex_branch};
    endfunction

    // Reference decoder written from the instruction-set table.
    function automatic dec_t ref_decode(input logic [31:0] ins);
        dec_t r;
        logic [5:0] op;
        logic [5:0] fn;
        r  = '0;
        op = ins[31:26];
        fn = ins[5:0];
        if (op == 6'h00) begin
            r.uses_rt = 1'b1;
            if (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25 || fn == 6'h2A) begin
                r.regwrite = 1'b1;
                r.dest     = ins[15:11];
                r.aluop    = (fn == 6'h20) ? 3'd0 : (fn == 6'h22) ? 3'd1 :
                             (fn == 6'h24) ? 3'd2 : (fn == 6'h25) ? 3'd3 : 3'd4;
            end
        end else if (op == 6'h23) begin
            r.alusrc = 1'b1; r.memread = 1'b1; r.regwrite = 1'b1; r.dest = ins[20:16];
        end else if (op == 6'h2B) begin
            r.alusrc = 1'b1; r.memwrite = 1'b1; r.uses_rt = 1'b1;
        end else if (op == 6'h04) begin
            r.aluop = 3'd1; r.branch = 1'b1; r.uses_rt = 1'b1;
        end else if (op == 6'h08) begin
            r.alusrc = 1'b1; r.regwrite = 1'b1; r.dest = ins[20:16];
        end
        return r;
    endfunction

    function automatic logic [31:0] ref_operand(input logic [4:0] src, input logic [31:0] rf,
                                                input logic we, input logic [4:0] wa,
                                                input logic [31:0] wd);
        if (src == 5'd0) return 32'd0;
        if (we && wa == src) return wd;
        return rf;
    endfunction

    function automatic logic [31:0] rnd_instr();
        logic [4:0]  s, t, d, sh;
        logic [15:0] im;
        logic [5:0]  fn;
        int k;
        s  = 5'($urandom_range(0, 3));
        t  = 5'($urandom_range(0, 3));
        d  = 5'($urandom_range(0, 3));
        sh = 5'($urandom);
        im = 16'($urandom);
        k  = $urandom_range(0, 9);
        case ($urandom_range(0, 5))
            0: fn = 6'h20;
            1: fn = 6'h22;
            2: fn = 6'h24;
            3: fn = 6'h25;
            4: fn = 6'h2A;
            default: fn = 6'h3F;
        endcase
        case (k)
            0, 1, 2: return {6'h23, s, t, im};
            3:       return {6'h2B, s, t, im};
            4:       return {6'h04, s, t, im};
            5:       return {6'h08, s, t, im};
            6:       return {6'h3F, s, t, im};
            default: return {6'h00, s, t, d, sh, fn};
        endcase
    endfunction

    task automatic drive(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2,
                         input logic we, input logic [4:0] wa, input logic [31:0] wd);
        if_valid = 1'b1;
        flush    = 1'b0;
        if_instr = ins;
        rf_data1 = r1;
        rf_data2 = r2;
        wb_we    = we;
        wb_addr  = wa;
        wb_data  = wd;
    endtask

    initial begin
        exm_t       m, n;
        dec_t       d;
        logic       hz, e_stall, hold;
        logic [CNT_W-1:0] mcnt;
        logic [31:0] ins;

        tbl[0]  = '{32'h00221820, 32'd5, 32'd7, 1'b0, 5'd0, 32'd0,
                    32'd5, 32'd7, 32'h00001820, 5'd3, 3'd0, 5'b00010};
        tbl[1]  = '{32'h00222022, 32'd9, 32'd0, 1'b1, 5'd2, 32'hDEADBEEF,
                    32'd9, 32'hDEADBEEF, 32'h00002022, 5'd4, 3'd1, 5'b00010};
        tbl[2]  = '{32'h00022820, 32'h0000FFFF, 32'd3, 1'b1, 5'd0, 32'h00001234,
                    32'd0, 32'd3, 32'h00002820, 5'd5, 3'd0, 5'b00010};
        tbl[3]  = '{32'h8C240008, 32'h00000100, 32'h00000055, 1'b0, 5'd0, 32'd0,
                    32'h00000100, 32'h00000055, 32'h00000008, 5'd4, 3'd0, 5'b11010};
        tbl[4]  = '{32'hAC47FFFC, 32'h00000010, 32'h00000020, 1'b0, 5'd0, 32'd0,
                    32'h00000010, 32'h00000020, 32'hFFFFFFFC, 5'd0, 3'd0, 5'b10100};
        tbl[5]  = '{32'h1022FFFF, 32'd3, 32'd3, 1'b0, 5'd0, 32'd0,
                    32'd3, 32'd3, 32'hFFFFFFFF, 5'd0, 3'd1, 5'b00001};
        tbl[6]  = '{32'h20667FFF, 32'h00000040, 32'h00000041, 1'b1, 5'd6, 32'h00000077,
                    32'h00000040, 32'h00000077, 32'h00007FFF, 5'd6, 3'd0, 5'b10010};
        tbl[7]  = '{32'h012A4024, 32'h0000F0F0, 32'h00000FF0, 1'b0, 5'd0, 32'd0,
                    32'h0000F0F0, 32'h00000FF0, 32'h00004024, 5'd8, 3'd2, 5'b00010};
        tbl[8]  = '{32'h018D5825, 32'd1, 32'd2, 1'b0, 5'd0, 32'd0,
                    32'd1, 32'd2, 32'h00005825, 5'd11, 3'd3, 5'b00010};
        tbl[9]  = '{32'h01F0702A, 32'hFFFFFFFF, 32'd1, 1'b0, 5'd0, 32'd0,
                    32'hFFFFFFFF, 32'd1, 32'h0000702A, 5'd14, 3'd4, 5'b00010};
        tbl[10] = '{32'hFC221820, 32'h00000011, 32'h00000022, 1'b0, 5'd0, 32'd0,
                    32'h00000011, 32'h00000022, 32'h00001820, 5'd0, 3'd0, 5'b00000};
        tbl[11] = '{32'h0022183F, 32'h00000011, 32'h00000022, 1'b0, 5'd0, 32'd0,
                    32'h00000011, 32'h00000022, 32'h0000183F, 5'd0, 3'd0, 5'b00000};
        tbl[12] = '{32'h00421820, 32'd1, 32'd1, 1'b1, 5'd2, 32'hCAFEF00D,
                    32'hCAFEF00D, 32'hCAFEF00D, 32'h00001820, 5'd3, 3'd0, 5'b00010};
        tbl[13] = '{32'h00221820, 32'h00000011, 32'h00000022, 1'b0, 5'd1, 32'h00000099,
                    32'h00000011, 32'h00000022, 32'h00001820, 5'd3, 3'd0, 5'b00010};

        drive(32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        if_valid = 1'b0;
        if_pc    = 32'd0;
        rst_n    = 1'b1;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_ex", get_ex(), '0);
        check("reset_cnt", stall_cnt, '0);
        @(negedge clk) rst_n = 1'b1;

        // Directed decode table
        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].instr, tbl[i].rf1, tbl[i].rf2, tbl[i].we, tbl[i].wa, tbl[i].wd);
            if_pc = 32'h400 + 32'(i * 4);
            ins   = tbl[i].instr;
            @(negedge clk);
            check("tbl_stall", id_stall, 1'b0);
            check("tbl_rfaddr", {rf_read1, rf_read2}, {ins[25:21], ins[20:16]});
            @(posedge clk);
            #1;
            check("tbl_ctl", {ex_valid, ex_dest, ex_aluop, ex_alusrc, ex_memread, ex_memwrite,
                              ex_regwrite, ex_branch},
                  {1'b1, tbl[i].e_dest, tbl[i].e_aluop, tbl[i].e_ctl});
            check("tbl_ops", {ex_rs_val, ex_rt_val}, {tbl[i].e_rs_val, tbl[i].e_rt_val});
            check("tbl_imm_pc", {ex_imm, ex_pc, ex_rs, ex_rt},
                  {tbl[i].e_imm, 32'h400 + 32'(i * 4), ins[25:21], ins[20:16]});
        end

        // Load-use: one stall, bubble, then the dependent add
        drive(32'h8C240008, 32'h100, 32'h0, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        check("lu_load_stall", id_stall, 1'b0);
        @(posedge clk); #1;
        check("lu_load", {ex_valid, ex_memread, ex_dest}, {1'b1, 1'b1, 5'd4});
        drive(32'h00842820, 32'h1, 32'h1, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        check("lu_stall", id_stall, 1'b1);
        @(posedge clk); #1;
        check("lu_bubble", {ex_valid, ex_aluop, ex_alusrc, ex_memread, ex_memwrite, ex_regwrite,
                            ex_branch, ex_dest}, '0);
        check("lu_cnt1", stall_cnt, 4'd1);
        @(negedge clk);
        check("lu_release", id_stall, 1'b0);
        @(posedge clk); #1;
        check("lu_add", {ex_valid, ex_dest, ex_regwrite, ex_rs, ex_rt}, {1'b1, 5'd5, 1'b1, 5'd4, 5'd4});
        check("lu_cnt_hold", stall_cnt, 4'd1);

        // Flush coincident with a load-use hazard
        drive(32'h8C240008, 32'h100, 32'h0, 1'b0, 5'd0, 32'd0);
        @(posedge clk); #1;
        drive(32'h00842820, 32'h1, 32'h1, 1'b0, 5'd0, 32'd0);
        flush = 1'b1;
        @(negedge clk);
        check("fl_stall", id_stall, 1'b0);
        @(posedge clk); #1;
        check("fl_bubble", {ex_valid, ex_regwrite, ex_memread, ex_dest}, '0);
        check("fl_cnt", stall_cnt, 4'd1);

        // Asynchronous reset in the middle of a stall
        drive(32'h8C240008, 32'h100, 32'h0, 1'b0, 5'd0, 32'd0);
        @(posedge clk); #1;
        drive(32'h00842820, 32'h1, 32'h1, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        check("rst_pre_stall", id_stall, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_async_ex", get_ex(), '0);
        check("rst_async_cnt", stall_cnt, '0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(32'h00221820, 32'd5, 32'd7, 1'b0, 5'd0, 32'd0);
        if_pc = 32'h800;
        @(posedge clk); #1;
        check("rst_first", {ex_valid, ex_rs_val, ex_rt_val, ex_dest, ex_pc},
              {1'b1, 32'd5, 32'd7, 5'd3, 32'h800});

        // Randomized run against the behavioural model
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        m    = '0;
        mcnt = '0;
        hold = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!hold) begin
                if_instr = rnd_instr();
                if_valid = ($urandom_range(0, 7) != 0);
            end
            flush    = ($urandom_range(0, 9) == 0);
            if_pc    = $urandom;
            rf_data1 = $urandom;
            rf_data2 = $urandom;
            wb_we    = $urandom_range(0, 1) != 0;
            wb_addr  = 5'($urandom_range(0, 3));
            wb_data  = $urandom;
            ins      = if_instr;
            d        = ref_decode(ins);
            hz       = if_valid && m.valid && m.memread && m.dest != 5'd0 &&
                       (m.dest == ins[25:21] || (d.uses_rt && m.dest == ins[20:16]));
            e_stall  = hz && !flush;
            if (flush || hz)
                n = '0;
            else
                n = '{valid: if_valid, pc: if_pc,
                      rs_val: ref_operand(ins[25:21], rf_data1, wb_we, wb_addr, wb_data),
                      rt_val: ref_operand(ins[20:16], rf_data2, wb_we, wb_addr, wb_data),
                      imm: {{16{ins[15]}}, ins[15:0]}, rs: ins[25:21], rt: ins[20:16],
                      dest: d.dest, aluop: d.aluop, alusrc: d.alusrc, memread: d.memread,
                      memwrite: d.memwrite, regwrite: d.regwrite, branch: d.branch};
            if (e_stall && mcnt != CNT_MAX)
                mcnt = mcnt + 1'b1;
            @(negedge clk);
            check("rnd_stall", id_stall, e_stall);
            check("rnd_rfaddr", {rf_read1, rf_read2}, {ins[25:21], ins[20:16]});
            @(posedge clk); #1;
            check("rnd_ex", get_ex(), n);
            check("rnd_cnt", stall_cnt, mcnt);
            m    = n;
            hold = e_stall;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
